// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-through, no-write-allocate data cache for
// the M stage. Misses refill a whole line over a word-wide backing-memory port and
// stores are always written through. StallM holds the pipeline while either is in flight.
// Optional feature macro: DCACHE_STATS_EN adds saturating HitCount/MissCount outputs.
module dcache_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [ADDR_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           HitCount,
    output logic [31:0]           MissCount
`endif
);

    localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W   = $clog2(SETS);
    localparam int unsigned IDX_LSB = OFF_W + 2;
    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
    localparam int unsigned TAG_W   = ADDR_WIDTH - TAG_LSB;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SETS-1:0]       valid_q;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS][LINE_WORDS];
    logic [OFF_W-1:0]      cnt;

    logic [OFF_W-1:0] in_off;
    logic [IDX_W-1:0] in_idx;
    logic [TAG_W-1:0] in_tag;
    logic [IDX_W-1:0] ref_idx;
    logic [TAG_W-1:0] ref_tag;
    logic             hit;
    logic             last_beat;
    logic             unused_addr_lsbs;

    // Address split of the M-stage request and of the in-flight refill line
    always_comb begin
        in_off           = ALUResultM[2 +: OFF_W];
        in_idx           = ALUResultM[IDX_LSB +: IDX_W];
        in_tag           = ALUResultM[TAG_LSB +: TAG_W];
        ref_idx          = mem_addr[IDX_LSB +: IDX_W];
        ref_tag          = mem_addr[TAG_LSB +: TAG_W];
        hit              = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
        last_beat        = mem_ready && (cnt == LAST_WORD);
        unused_addr_lsbs = ^ALUResultM[1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a simultaneous read and write is handled as a write
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (MemWriteM) begin
                    state_nxt = WRITE;
                end else if (MemReadM && !hit) begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                if (last_beat) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pipeline-facing outputs: same-cycle hit data, stall while a transfer is pending
    always_comb begin
        StallM    = 1'b0;
        ReadDataM = '0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (MemWriteM) begin
                        StallM = 1'b1;
                    end else if (MemReadM) begin
                        if (hit) begin
                            ReadDataM = data_q[in_idx][in_off];
                        end else begin
                            StallM = 1'b1;
                        end
                    end
                end
                REFILL:  StallM = 1'b1;
                WRITE:   StallM = !mem_ready;
                default: StallM = 1'b0;
            endcase
        end
    end

    // Backing-memory request registers, refill word counter and line valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MemWriteM) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata <= WriteDataM;
                    end else if (MemReadM && !hit) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {ALUResultM[ADDR_WIDTH-1:IDX_LSB], {(OFF_W + 2){1'b0}}};
                        cnt      <= '0;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        cnt <= cnt + OFF_W'(1);
                        if (cnt == LAST_WORD) begin
                            mem_req          <= 1'b0;
                            valid_q[ref_idx] <= 1'b1;
                        end else begin
                            mem_addr <= mem_addr + ADDR_WIDTH'(4);
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: mem_req <= 1'b0;
            endcase
        end
    end

    // Line storage: store hits update the word on entry to WRITE, refill beats fill the line
    always_ff @(posedge clk) begin
        if (!reset) begin
            if ((state == IDLE) && MemWriteM && hit) begin
                data_q[in_idx][in_off] <= WriteDataM;
            end
            if ((state == REFILL) && mem_ready) begin
                data_q[ref_idx][cnt] <= mem_rdata;
                if (cnt == LAST_WORD) begin
                    tag_q[ref_idx] <= ref_tag;
                end
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic refill_done;
    logic load_idle;

    assign load_idle = (state == IDLE) && MemReadM && !MemWriteM;

    // Saturating hit/miss counters; the replayed load right after a refill is not a hit
    always_ff @(posedge clk) begin
        if (reset) begin
            HitCount    <= '0;
            MissCount   <= '0;
            refill_done <= 1'b0;
        end else begin
            refill_done <= (state == REFILL) && last_beat;
            if (load_idle && hit && !refill_done && (HitCount != '1)) begin
                HitCount <= HitCount + 32'd1;
            end
            if (load_idle && !hit && (MissCount != '1)) begin
                MissCount <= MissCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: directed scenarios then randomized loads/stores against a
// line-level cache model. Expectations are queued at issue; a monitor pops and compares.
module tb_dcache_responder;

    localparam int unsigned SETS       = 64;
    localparam int unsigned LW         = 4;
    localparam int unsigned LINE_BYTES = LW * 4;
    localparam int unsigned SPAN       = SETS * LINE_BYTES;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
`ifdef DCACHE_STATS_EN
    logic [31:0] HitCount;
    logic [31:0] MissCount;
`endif

    dcache_responder dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .HitCount   (HitCount),
        .MissCount  (MissCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    // Reference model: which line each set holds, and what memory contains
    bit          m_valid [SETS];
    bit [31:0]   m_tag   [SETS];
    bit [31:0]   ref_mem [bit [31:0]];
    bit [31:0]   bmem    [bit [31:0]];
    int unsigned m_hits;
    int unsigned m_misses;

    txn_t      exp_mem[$];
    bit [31:0] exp_rd[$];
    int        exp_stall[$];
    int        wait_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;
    int cur_wait = -1;

    function automatic bit [31:0] mem_default(input bit [31:0] a);
        return (a >> 2) + 32'h60;
    endfunction

    function automatic bit [31:0] ref_read(input bit [31:0] wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return mem_default(wa);
    endfunction

    function automatic int pick(input int lo, input int hi);
        return lo + int'($urandom_range(32'(hi - lo)));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    endtask

    // Backing memory: waits come from the stimulus, ready/rdata are noise while idle
    always @(negedge clk) begin
        if (mem_req) begin
            if (cur_wait < 0) begin
                if (wait_q.size() > 0) cur_wait = wait_q.pop_front();
                else cur_wait = 0;
            end
            if (cur_wait == 0) begin
                mem_ready = 1'b1;
                if (mem_we) begin
                    bmem[mem_addr] = mem_wdata;
                    mem_rdata = $urandom();
                end else if (bmem.exists(mem_addr)) begin
                    mem_rdata = bmem[mem_addr];
                end else begin
                    mem_rdata = mem_default(mem_addr);
                end
                cur_wait = -1;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom();
                cur_wait--;
            end
        end else begin
            mem_ready = 1'($urandom_range(1));
            mem_rdata = $urandom();
        end
    end

    // Monitor: compares memory transfers, stall lengths and retired load data
    always begin : monitor
        txn_t t;
        int   stall_cnt;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (reset || !mon_en) begin
                stall_cnt = 0;
            end else begin
                if (mem_req && mem_ready) begin
                    if (exp_mem.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_mem_txn: got we=%0b addr=0x%08h, expected none",
                                 mem_we, mem_addr);
                    end else begin
                        t = exp_mem.pop_front();
                        check("mem_we", 32'(mem_we), 32'(t.we));
                        check("mem_addr", mem_addr, t.addr);
                        if (t.we) check("mem_wdata", mem_wdata, t.data);
                    end
                end
                if (StallM) begin
                    stall_cnt++;
                end else begin
                    if (exp_stall.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_retire: got retire, expected no op");
                    end else begin
                        check("stall_cycles", 32'(stall_cnt), 32'(exp_stall.pop_front()));
                    end
                    if (MemReadM && !MemWriteM) begin
                        if (exp_rd.size() == 0) begin
                            n_checks++;
                            $display("FAIL unexpected_load: got 0x%08h, expected none", ReadDataM);
                        end else begin
                            check("load_data", ReadDataM, exp_rd.pop_front());
                        end
                    end else begin
                        check("rdata_zero", ReadDataM, 32'h0);
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    // Issue one M-stage op, queue its expected effects, hold it until it retires
    task automatic do_op(input bit rd, input bit wr, input bit [31:0] a, input bit [31:0] d,
                         input int wlo, input int whi);
        bit [31:0] wa;
        bit [31:0] base;
        bit [31:0] tag;
        int        idx;
        int        stall;
        int        w;
        int        cyc;
        bit        done;
        wa    = {a[31:2], 2'b00};
        base  = a - (a % LINE_BYTES);
        idx   = int'((a / LINE_BYTES) % SETS);
        tag   = a / SPAN;
        stall = 0;
        if (wr) begin
            w = pick(wlo, whi);
            wait_q.push_back(w);
            exp_mem.push_back(txn_t'{1'b1, wa, d});
            ref_mem[wa] = d;
            stall = 1 + w;
        end else if (rd) begin
            if (m_valid[idx] && m_tag[idx] == tag) begin
                m_hits++;
            end else begin
                m_misses++;
                stall = 1;
                for (int i = 0; i < LW; i++) begin
                    w = pick(wlo, whi);
                    wait_q.push_back(w);
                    exp_mem.push_back(txn_t'{1'b0, base + 32'(4 * i), 32'h0});
                    stall += w + 1;
                end
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
            end
            exp_rd.push_back(ref_read(wa));
        end
        exp_stall.push_back(stall);
        mon_en     = 1'b1;
        MemReadM   = rd;
        MemWriteM  = wr;
        ALUResultM = a;
        WriteDataM = d;
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            #3;
            if (!StallM) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
                if (cyc > 300) begin
                    n_checks++;
                    $display("FAIL op_timeout: got StallM stuck for %0d cycles, expected retire", cyc);
                    $fatal(1, "op did not retire");
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit [31:0] a;
        int        r;
        reset      = 1'b1;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        m_hits     = 0;
        m_misses   = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #3;
        check("rst_rdata", ReadDataM, 32'h0);
        check("rst_stall", 32'(StallM), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);

        // Directed: cold refill, hit, store hit with waits, store miss, eviction
        do_op(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 0);
        do_op(1'b1, 1'b0, 32'h0000_0108, 32'h0, 0, 0);
        do_op(1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 2, 2);
        do_op(1'b1, 1'b0, 32'h0000_0104, 32'h0, 0, 0);
        do_op(1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 0, 0);
        do_op(1'b1, 1'b0, 32'h0000_2000, 32'h0, 0, 1);
        do_op(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 0);
        do_op(1'b1, 1'b0, 32'h0000_0100 + SPAN, 32'h0, 0, 0);
        do_op(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 2);
        do_op(1'b1, 1'b1, 32'h0000_0108, 32'hCAFE_F00D, 1, 1);
        do_op(1'b0, 1'b0, 32'h0000_0108, 32'h0, 0, 0);
        do_op(1'b1, 1'b0, 32'h0000_0108, 32'h0, 0, 0);

        // Reset in the second cycle of a refill aborts it and clears every line
        mon_en     = 1'b0;
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        ALUResultM = 32'h0000_5040;
        @(negedge clk);
        #3;
        check("refill_req_up", 32'(mem_req), 32'h1);
        @(negedge clk);
        reset    = 1'b1;
        MemReadM = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #3;
        check("abort_mem_req", 32'(mem_req), 32'h0);
        check("abort_stall", 32'(StallM), 32'h0);
        check("abort_mem_we", 32'(mem_we), 32'h0);
        check("abort_rdata", ReadDataM, 32'h0);
`ifdef DCACHE_STATS_EN
        check("abort_hits", HitCount, 32'h0);
        check("abort_misses", MissCount, 32'h0);
`endif
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        @(negedge clk);
        do_op(1'b1, 1'b0, 32'h0000_5040, 32'h0, 0, 0);
        do_op(1'b1, 1'b0, 32'h0000_0108, 32'h0, 0, 0);

        // Random traffic over a few tags and sets, random byte offsets and wait states
        for (int k = 0; k < 200; k++) begin
            a = 32'($urandom_range(3)) * SPAN + 32'($urandom_range(7)) * LINE_BYTES
              + 32'($urandom_range(3)) * 4 + 32'($urandom_range(3));
            r = int'($urandom_range(99));
            if (r < 45)      do_op(1'b1, 1'b0, a, 32'h0, 0, 2);
            else if (r < 75) do_op(1'b0, 1'b1, a, $urandom(), 0, 2);
            else if (r < 85) do_op(1'b1, 1'b1, a, $urandom(), 0, 2);
            else             do_op(1'b0, 1'b0, a, 32'h0, 0, 0);
        end
        mon_en    = 1'b0;
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        #3;
        check("exp_mem_drained", 32'(exp_mem.size()), 32'h0);
        check("exp_rd_drained", 32'(exp_rd.size()), 32'h0);
        check("exp_stall_drained", 32'(exp_stall.size()), 32'h0);
`ifdef DCACHE_STATS_EN
        check("hit_count", HitCount, 32'(m_hits));
        check("miss_count", MissCount, 32'(m_misses));
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
